// File: rtl/canvas_renderer_if.sv
// Pixel / cursor / RAM / colour bus for the canvas renderer.
// The master drives pixel coordinates, cursor data, mode and RAM read data.
// The slave (renderer) drives the RAM read address and the colour output.
interface canvas_renderer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              pix_valid;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        BallX;
    logic [9:0]        BallY;
    logic [9:0]        Ball_size;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        Red;
    logic [7:0]        Green;
    logic [7:0]        Blue;
    logic              rgb_valid;

    modport master (
        output pix_valid, DrawX, DrawY, BallX, BallY, Ball_size, mode, rd_data,
        input  rd_addr, Red, Green, Blue, rgb_valid
    );

    modport slave (
        input  pix_valid, DrawX, DrawY, BallX, BallY, Ball_size, mode, rd_data,
        output rd_addr, Red, Green, Blue, rgb_valid
    );
endinterface

// File: rtl/canvas_renderer.sv
// Two-stage pixel renderer for a GRID_N x GRID_N canvas of CELL_PX-pixel cells.
// Stage 1 maps the pixel to a cell address and evaluates canvas, grid-line and
// cursor hits; stage 2 combines those flags with the RAM word into a colour.
// The cursor centre/radius are latched once per frame at pixel (0,0).
module canvas_renderer #(
    parameter int GRID_N   = 28,
    parameter int CELL_PX  = 14,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0,
    parameter int DATA_W   = 16,
    parameter int LUMA_LSB = 4,
    parameter int ADDR_W   = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    canvas_renderer_if.slave  bus
);

    localparam int          CANVAS_PX = GRID_N * CELL_PX;
    localparam logic [10:0] X_LO      = 11'(ORIGIN_X);
    localparam logic [10:0] Y_LO      = 11'(ORIGIN_Y);
    localparam logic [10:0] SPAN      = 11'(CANVAS_PX);
    localparam logic [9:0]  CELL_W    = 10'(CELL_PX);

    // Cursor state latched at frame start
    logic [9:0] ball_x_q, ball_x_d;
    logic [9:0] ball_y_q, ball_y_d;
    logic [9:0] ball_s_q, ball_s_d;

    // Stage-1 registers
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_canvas_q, s1_canvas_d;
    logic              s1_cursor_q, s1_cursor_d;
    logic              s1_grid_q, s1_grid_d;
    logic [1:0]        s1_mode_q, s1_mode_d;

    // Stage-2 registers
    logic [7:0] red_q, red_d;
    logic [7:0] green_q, green_d;
    logic [7:0] blue_q, blue_d;
    logic       rgb_valid_q, rgb_valid_d;

    // Stage-1 combinational terms
    logic        frame_start;
    logic [10:0] rel_x, rel_y;
    logic        on_canvas;
    logic [9:0]  col, row;
    logic [9:0]  mod_x, mod_y;
    logic        grid_line;
    logic [10:0] dx, dy;
    logic [10:0] adx, ady;
    logic [21:0] dist_sq;
    logic [21:0] rad_sq;
    logic        cursor_hit;

    // Stage-2 combinational terms
    logic [7:0] luma;
    logic [7:0] gray;

    // Stage 1: address mapping, hit tests and cursor latch selection
    always_comb begin
        frame_start = bus.pix_valid && (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);

        // The frame-start pixel itself already uses the freshly latched cursor.
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        ball_s_d = ball_s_q;
        if (frame_start) begin
            ball_x_d = bus.BallX;
            ball_y_d = bus.BallY;
            ball_s_d = bus.Ball_size;
        end else begin
            ball_x_d = ball_x_q;
            ball_y_d = ball_y_q;
            ball_s_d = ball_s_q;
        end

        // Pixels left/above the origin wrap to a large value and fail the span test.
        rel_x     = {1'b0, bus.DrawX} - X_LO;
        rel_y     = {1'b0, bus.DrawY} - Y_LO;
        on_canvas = (rel_x < SPAN) && (rel_y < SPAN);
        col       = rel_x[9:0] / CELL_W;
        row       = rel_y[9:0] / CELL_W;
        mod_x     = rel_x[9:0] % CELL_W;
        mod_y     = rel_y[9:0] % CELL_W;
        grid_line = on_canvas && ((mod_x == 10'd0) || (mod_y == 10'd0));

        // Squared distance on magnitudes keeps the products unsigned and exact.
        dx         = {1'b0, bus.DrawX} - {1'b0, ball_x_d};
        dy         = {1'b0, bus.DrawY} - {1'b0, ball_y_d};
        adx        = dx[10] ? (11'd0 - dx) : dx;
        ady        = dy[10] ? (11'd0 - dy) : dy;
        dist_sq    = (22'(adx) * 22'(adx)) + (22'(ady) * 22'(ady));
        rad_sq     = 22'(ball_s_d) * 22'(ball_s_d);
        cursor_hit = (ball_s_d != 10'd0) && (dist_sq <= rad_sq);

        rd_addr_d   = rd_addr_q;
        s1_valid_d  = 1'b0;
        s1_canvas_d = s1_canvas_q;
        s1_cursor_d = s1_cursor_q;
        s1_grid_d   = s1_grid_q;
        s1_mode_d   = s1_mode_q;
        if (bus.pix_valid) begin
            rd_addr_d   = on_canvas ? (ADDR_W'(row) * ADDR_W'(GRID_N) + ADDR_W'(col))
                                    : {ADDR_W{1'b0}};
            s1_valid_d  = 1'b1;
            s1_canvas_d = on_canvas;
            s1_cursor_d = cursor_hit;
            s1_grid_d   = grid_line;
            s1_mode_d   = bus.mode;
        end else begin
            s1_valid_d  = 1'b0;
        end
    end

    // Stage-1 and cursor registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ball_x_q    <= 10'd0;
            ball_y_q    <= 10'd0;
            ball_s_q    <= 10'd0;
            rd_addr_q   <= {ADDR_W{1'b0}};
            s1_valid_q  <= 1'b0;
            s1_canvas_q <= 1'b0;
            s1_cursor_q <= 1'b0;
            s1_grid_q   <= 1'b0;
            s1_mode_q   <= 2'd0;
        end else begin
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            ball_s_q    <= ball_s_d;
            rd_addr_q   <= rd_addr_d;
            s1_valid_q  <= s1_valid_d;
            s1_canvas_q <= s1_canvas_d;
            s1_cursor_q <= s1_cursor_d;
            s1_grid_q   <= s1_grid_d;
            s1_mode_q   <= s1_mode_d;
        end
    end

    // Stage 2: colour selection; bubbles hold the previous colour
    always_comb begin
        luma = bus.rd_data[LUMA_LSB+7:LUMA_LSB];

        case (s1_mode_q)
            2'd0:    gray = luma;
            2'd1:    gray = 8'hFF - luma;
            2'd2:    gray = s1_grid_q ? 8'h40 : luma;
            2'd3:    gray = (luma >= 8'h80) ? 8'hFF : 8'h00;
            default: gray = luma;
        endcase

        red_d       = red_q;
        green_d     = green_q;
        blue_d      = blue_q;
        rgb_valid_d = 1'b0;
        if (s1_valid_q) begin
            rgb_valid_d = 1'b1;
            if (s1_cursor_q) begin
                red_d   = 8'hFF;
                green_d = 8'h00;
                blue_d  = 8'h00;
            end else if (s1_canvas_q) begin
                red_d   = gray;
                green_d = gray;
                blue_d  = gray;
            end else begin
                red_d   = 8'h00;
                green_d = 8'h00;
                blue_d  = 8'h00;
            end
        end else begin
            rgb_valid_d = 1'b0;
        end
    end

    // Stage-2 output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            red_q       <= 8'd0;
            green_q     <= 8'd0;
            blue_q      <= 8'd0;
            rgb_valid_q <= 1'b0;
        end else begin
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            rgb_valid_q <= rgb_valid_d;
        end
    end

    assign bus.rd_addr   = rd_addr_q;
    assign bus.Red       = red_q;
    assign bus.Green     = green_q;
    assign bus.Blue      = blue_q;
    assign bus.rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_canvas_renderer.sv
// Scoreboard bench for canvas_renderer with default parameters.
// Each driven cycle pushes its expected output; the entry is compared two
// edges later, so latency, bubbles and held colours are all checked.
module tb_canvas_renderer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    canvas_renderer_if #(.ADDR_W(10), .DATA_W(16)) bus ();

    canvas_renderer dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    logic [15:0] mem [0:1023];
    assign bus.rd_data = mem[bus.rd_addr];

    typedef struct {
        logic       v;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Driven cursor inputs and mode
    int cur_bx = 0;
    int cur_by = 0;
    int cur_bs = 0;
    int cur_md = 0;

    // Reference model state
    int         m_bx = 0;
    int         m_by = 0;
    int         m_bs = 0;
    logic [7:0] m_r  = 8'h00;
    logic [7:0] m_g  = 8'h00;
    logic [7:0] m_b  = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, update model, advance, compare
    task automatic step(input logic r, input logic v, input int x, input int y);
        exp_t       e;
        exp_t       z;
        int         ea;
        logic       on;
        logic       grid;
        logic       hit;
        logic [15:0] w;
        logic [7:0] l;
        logic [7:0] gr;
        int         ddx;
        int         ddy;

        ea = 0;
        rst           = r;
        bus.pix_valid = v;
        bus.DrawX     = 10'(x);
        bus.DrawY     = 10'(y);
        bus.BallX     = 10'(cur_bx);
        bus.BallY     = 10'(cur_by);
        bus.Ball_size = 10'(cur_bs);
        bus.mode      = 2'(cur_md);

        if (!r) begin
            if (v) begin
                if (x == 0 && y == 0) begin
                    m_bx = cur_bx;
                    m_by = cur_by;
                    m_bs = cur_bs;
                end
                on   = (x >= 0) && (x < 392) && (y >= 0) && (y < 392);
                ea   = on ? ((y / 14) * 28 + (x / 14)) : 0;
                w    = mem[ea];
                l    = w[11:4];
                grid = on && ((x % 14 == 0) || (y % 14 == 0));
                ddx  = x - m_bx;
                ddy  = y - m_by;
                hit  = (m_bs != 0) && (ddx * ddx + ddy * ddy <= m_bs * m_bs);
                case (cur_md)
                    0:       gr = l;
                    1:       gr = 8'hFF - l;
                    2:       gr = grid ? 8'h40 : l;
                    default: gr = (l >= 8'h80) ? 8'hFF : 8'h00;
                endcase
                if (hit) begin
                    m_r = 8'hFF; m_g = 8'h00; m_b = 8'h00;
                end else if (on) begin
                    m_r = gr; m_g = gr; m_b = gr;
                end else begin
                    m_r = 8'h00; m_g = 8'h00; m_b = 8'h00;
                end
            end
            e.v = v;
            e.r = m_r;
            e.g = m_g;
            e.b = m_b;
            sb.push_back(e);
        end

        @(posedge clk);
        #1;

        if (r) begin
            sb.delete();
            m_bx = 0; m_by = 0; m_bs = 0;
            m_r = 8'h00; m_g = 8'h00; m_b = 8'h00;
            check_eq("rst_rgb_valid", 32'(bus.rgb_valid), 32'd0);
            check_eq("rst_rgb", {8'h00, bus.Red, bus.Green, bus.Blue}, 32'd0);
            check_eq("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
            // The pipeline is empty after reset: next output slot is a bubble.
            z.v = 1'b0; z.r = 8'h00; z.g = 8'h00; z.b = 8'h00;
            sb.push_back(z);
        end else begin
            if (v) check_eq("rd_addr", 32'(bus.rd_addr), 32'(ea));
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                check_eq("rgb_valid", 32'(bus.rgb_valid), 32'(e.v));
                check_eq("rgb", {8'h00, bus.Red, bus.Green, bus.Blue},
                         {8'h00, e.r, e.g, e.b});
            end
        end
    endtask

    task automatic drain();
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0A50;

        // Reset
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);

        // Address map and off-canvas black (cursor disabled after reset)
        cur_md = 0;
        step(1'b0, 1'b1, 27, 15);
        step(1'b0, 1'b1, 391, 391);
        step(1'b0, 1'b1, 392, 0);
        step(1'b0, 1'b1, 0, 392);
        drain();

        // Luma and modes on cell 0 (word 16'h0A50)
        cur_md = 0; step(1'b0, 1'b1, 5, 5);
        cur_md = 1; step(1'b0, 1'b1, 5, 5);
        cur_md = 3; step(1'b0, 1'b1, 5, 5);
        cur_md = 2; step(1'b0, 1'b1, 14, 5);
        cur_md = 2; step(1'b0, 1'b1, 5, 5);
        drain();

        // Cursor latch at frame start, then BallX changed mid-frame
        cur_md = 0; cur_bx = 100; cur_by = 100; cur_bs = 3;
        step(1'b0, 1'b1, 0, 0);
        cur_bx = 200;
        step(1'b0, 1'b1, 103, 100);
        step(1'b0, 1'b1, 104, 100);
        step(1'b0, 1'b1, 200, 100);
        step(1'b0, 1'b1, 100, 97);
        step(1'b0, 1'b1, 102, 102);
        drain();

        // Bubbles: 1,0,1,1
        cur_md = 1;
        step(1'b0, 1'b1, 30, 40);
        step(1'b0, 1'b0, 31, 40);
        step(1'b0, 1'b1, 32, 40);
        step(1'b0, 1'b1, 33, 40);
        drain();

        // Random traffic with mode changes, bubbles and occasional frame starts
        for (int k = 0; k < 300; k++) begin
            cur_md = int'($urandom_range(0, 3));
            cur_bx = int'($urandom_range(0, 420));
            cur_by = int'($urandom_range(0, 420));
            cur_bs = int'($urandom_range(0, 40));
            if ($urandom_range(0, 15) == 0)
                step(1'b0, 1'b1, 0, 0);
            else
                step(1'b0, ($urandom_range(0, 3) != 0),
                     int'($urandom_range(0, 430)), int'($urandom_range(0, 430)));
        end

        // Reset with two pixels in flight
        cur_md = 0; cur_bx = 20; cur_by = 20; cur_bs = 30;
        step(1'b0, 1'b1, 0, 0);
        step(1'b0, 1'b1, 20, 20);
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        // Cursor disabled until the next frame start
        cur_bx = 5; cur_by = 5; cur_bs = 10;
        step(1'b0, 1'b1, 5, 5);
        cur_bs = 0;
        step(1'b0, 1'b1, 0, 0);
        step(1'b0, 1'b1, 1, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/canvas_renderer.md
CANVAS_RENDERER -- requirements
Module: canvas_renderer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter GRID_N, default 28, SHALL set the number of canvas cells per side.
REQ-003 Parameter CELL_PX, default 14, SHALL set the cell edge length in pixels.
REQ-004 Parameters ORIGIN_X and ORIGIN_Y, default 0, SHALL set the canvas top-left pixel.
REQ-005 Parameter DATA_W, default 16, SHALL set the cell word width.
REQ-006 Parameter LUMA_LSB, default 4, SHALL set the lowest bit of the 8-bit luma field within a cell word.
REQ-007 Parameter ADDR_W, default 10, SHALL set the address width, and it SHALL satisfy 2^ADDR_W >= GRID_N*GRID_N.
REQ-008 Ports SHALL be:
- Clk  in  1  clock
- Reset  in  1  synchronous active-high reset
- pix_valid  in  1  DrawX/DrawY valid this cycle
- DrawX, DrawY  in  10  pixel coordinate
- BallX, BallY, Ball_size  in  10  cursor centre and radius
- mode  in  2  render mode
- rd_addr  out  ADDR_W  canvas RAM read address
- rd_data  in  DATA_W  RAM word, one cycle after rd_addr
- Red, Green, Blue  out  8  pixel colour
- rgb_valid  out  1  RGB is valid this cycle

Function
REQ-009 A pixel is on the canvas iff ORIGIN_X <= DrawX < ORIGIN_X+GRID_N*CELL_PX and ORIGIN_Y <= DrawY < ORIGIN_Y+GRID_N*CELL_PX.
REQ-010 The cell indices SHALL be col=(DrawX-ORIGIN_X)/CELL_PX and row=(DrawY-ORIGIN_Y)/CELL_PX, with row-major address row*GRID_N+col.
REQ-011 Stage 1 SHALL occur at the edge sampling pix_valid=1: register rd_addr, the canvas-hit flag, the cursor-hit flag, the grid-line flag and valid.
REQ-012 rd_addr SHALL be registered as 0 for off-canvas pixels, and rd_data SHALL then be ignored.
REQ-013 Stage 2 SHALL occur one edge later: register Red/Green/Blue and rgb_valid from the stage-1 flags and rd_data.
- Fixed latency: 2 cycles.
- Throughput: one pixel per cycle.
REQ-014 Cycles with pix_valid=0 SHALL propagate as bubbles.
- rgb_valid=0 for the bubble.
- RGB holds its last value.
REQ-015 The cursor registers SHALL latch BallX, BallY and Ball_size only on pix_valid=1 with DrawX=0 and DrawY=0 (frame start); that same pixel SHALL use the newly latched values.
REQ-016 The cursor hit SHALL be dx*dx+dy*dy <= size*size.
- dx, dy: 11-bit signed differences DrawX-BallX and DrawY-BallY.
- Sums: at least 22 bits, unsigned, no truncation.
- Latched size 0 disables the cursor.
REQ-017 The grid-line flag SHALL be true on-canvas where (DrawX-ORIGIN_X)%CELL_PX==0 or (DrawY-ORIGIN_Y)%CELL_PX==0.
REQ-018 The luma value L SHALL be rd_data[LUMA_LSB+7:LUMA_LSB].
REQ-019 Colour priority SHALL be: cursor (FF,00,00), then canvas, then background (00,00,00).
REQ-020 For canvas pixels, R=G=B SHALL be:
- mode 0: L
- mode 1: 8'hFF-L
- mode 2: 8'h40 on grid-line pixels, else L
- mode 3: 8'hFF if L>=8'h80, else 8'h00
REQ-021 mode SHALL be sampled in stage 1, so a mode change takes effect on the next accepted pixel without glitching pixels already in flight.
REQ-022 The block SHALL provide no backpressure; pix_valid is always accepted.

Reset
REQ-023 While Reset=1 at an edge, the block SHALL clear:
- rd_addr to 0
- all stage flags and valids to 0
- Red, Green and Blue to 0
- rgb_valid to 0
- the latched cursor X, Y and size to 0 (cursor disabled)
REQ-024 A reset mid-frame SHALL discard in-flight pixels, produce no rgb_valid for them, and leave the cursor disabled until the next frame start.
REQ-025 The first pixel with pix_valid=1 after reset deasserts SHALL produce rgb_valid exactly 2 cycles later.

Verification
REQ-026 Address map: defaults, pix_valid at (DrawX=27,DrawY=15) -> next cycle rd_addr=29 (row 1, col 1); at (391,391) -> rd_addr=783; at (392,0) -> rd_addr=0, output black.
REQ-027 Luma and modes: RAM word 16'h0A50 at cell 0, pixel (5,5) -> mode 0 RGB=A5,A5,A5; mode 1 RGB=5A,5A,5A; mode 3 RGB=FF,FF,FF; mode 2 at pixel (14,5) RGB=40,40,40; each with rgb_valid 2 cycles after pix_valid.
REQ-028 Cursor latch: BallX=100, BallY=100, Ball_size=3 at frame start, then BallX changed to 200 mid-frame -> pixel (103,100) red, pixel (104,100) not red, pixel (200,100) not red until the next frame start.
REQ-029 Bubbles: pix_valid pattern 1,0,1,1 -> rgb_valid pattern 1,0,1,1 delayed by 2 cycles, with RGB held during the bubble.
REQ-030 Reset mid-stream: Reset=1 for one cycle while 2 pixels are in flight -> rgb_valid stays 0 for those pixels, RGB=0, cursor disabled (size-0 check at (0,0) shows canvas colour).
